// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller: selector codes,
// opcode/funct values, FSM states, writeback kinds and operand-select codes.
package alu_pkg;

  localparam logic [4:0] SEL_ADD  = 5'b10000;
  localparam logic [4:0] SEL_NOR  = 5'b10011;
  localparam logic [4:0] SEL_NORI = 5'b00111;
  localparam logic [4:0] SEL_NOT  = 5'b00010;
  localparam logic [4:0] SEL_BLEU = 5'b01000;
  localparam logic [4:0] SEL_ROLV = 5'b00000;
  localparam logic [4:0] SEL_RORV = 5'b00001;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_NORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BLEU  = 6'h07;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_NOT  = 6'h28;
  localparam logic [5:0] FN_ROLV = 6'h04;
  localparam logic [5:0] FN_RORV = 6'h06;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  typedef enum logic [1:0] {
    WB_REG    = 2'b00,
    WB_LOAD   = 2'b01,
    WB_STORE  = 2'b10,
    WB_BRANCH = 2'b11
  } wb_kind_t;

  typedef enum logic [0:0] {I1_ZERO, I1_RS} i1_sel_t;

  typedef enum logic [2:0] {I2_ZERO, I2_RT, I2_RS, I2_ZEXT, I2_SEXT} i2_sel_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Writeback channel from the issue controller to regfile/LSU/branch logic.
// The controller is the master; downstream drives wb_ready.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);

  logic              wb_valid;
  logic              wb_ready;
  logic [1:0]        wb_kind;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] wb_store_data;
  logic              branch_taken;

  modport master (
    output wb_valid, wb_kind, wb_addr, wb_data, wb_store_data, branch_taken,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_kind, wb_addr, wb_data, wb_store_data, branch_taken,
    output wb_ready
  );

endinterface

// File: rtl/alu_decode.sv
// Combinational instruction decode: op/funct to ALU selector, operand sources,
// writeback kind, destination register and legality.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [4:0] sel,
  output i1_sel_t    i1_sel,
  output i2_sel_t    i2_sel,
  output wb_kind_t   kind,
  output logic [4:0] dest,
  output logic       reg_write,
  output logic       is_legal
);

  always_comb begin
    sel       = 5'b0;
    i1_sel    = I1_ZERO;
    i2_sel    = I2_ZERO;
    kind      = WB_REG;
    dest      = 5'b0;
    reg_write = 1'b0;
    is_legal  = 1'b0;

    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADD || funct == FN_NOR || funct == FN_NOT ||
            funct == FN_ROLV || funct == FN_RORV) begin
          dest      = rd;
          reg_write = 1'b1;
          is_legal  = 1'b1;
          i1_sel    = I1_RS;
          i2_sel    = I2_RT;
        end
        case (funct)
          FN_ADD:  sel = SEL_ADD;
          FN_NOR:  sel = SEL_NOR;
          FN_ROLV: sel = SEL_ROLV;
          FN_RORV: sel = SEL_RORV;
          // not is computed by the ALU as ~I2, so rs goes on the second operand
          FN_NOT: begin
            sel    = SEL_NOT;
            i1_sel = I1_ZERO;
            i2_sel = I2_RS;
          end
          default: sel = 5'b0;
        endcase
      end
      OP_NORI: begin
        sel       = SEL_NORI;
        i1_sel    = I1_RS;
        i2_sel    = I2_ZEXT;
        dest      = rt;
        reg_write = 1'b1;
        is_legal  = 1'b1;
      end
      OP_LW: begin
        sel      = SEL_ADD;
        i1_sel   = I1_RS;
        i2_sel   = I2_SEXT;
        kind     = WB_LOAD;
        dest     = rt;
        is_legal = 1'b1;
      end
      OP_SW: begin
        sel      = SEL_ADD;
        i1_sel   = I1_RS;
        i2_sel   = I2_SEXT;
        kind     = WB_STORE;
        is_legal = 1'b1;
      end
      OP_BLEU: begin
        sel      = SEL_BLEU;
        i1_sel   = I1_RS;
        i2_sel   = I2_RT;
        kind     = WB_BRANCH;
        is_legal = 1'b1;
      end
      default: is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multicycle ALU issue controller: IDLE -> DECODE -> EXEC -> WB, one instruction
// at a time. Define ALU_ILLEGAL_TRAP_EN to pulse 'illegal' on unknown op/funct.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [4:0]        alu_sel,
  output logic [DATA_W-1:0] alu_i1,
  output logic [DATA_W-1:0] alu_i2,
  input  logic [DATA_W-1:0] alu_o,
  alu_issue_ctrl_if.master  wb,
  output logic              illegal
);

  state_t            state, state_next;
  logic [31:0]       instr_q;
  wb_kind_t          kind_q;
  logic [REG_AW-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] store_q;
  logic              taken_q;

  logic [4:0] sel;
  i1_sel_t    i1_sel;
  i2_sel_t    i2_sel;
  wb_kind_t   kind;
  logic [4:0] dest;
  logic       reg_write;
  logic       is_legal;

  alu_decode u_decode (
    .op        (instr_q[31:26]),
    .funct     (instr_q[5:0]),
    .rt        (instr_q[20:16]),
    .rd        (instr_q[15:11]),
    .sel       (sel),
    .i1_sel    (i1_sel),
    .i2_sel    (i2_sel),
    .kind      (kind),
    .dest      (dest),
    .reg_write (reg_write),
    .is_legal  (is_legal)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Result registers are loaded at the end of EXEC and held for the whole WB phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_q <= '0;
      kind_q  <= WB_REG;
      addr_q  <= '0;
      data_q  <= '0;
      store_q <= '0;
      taken_q <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid) instr_q <= instr;
      if (state == EXEC) begin
        data_q  <= alu_o;
        kind_q  <= kind;
        addr_q  <= REG_AW'(dest);
        store_q <= (kind == WB_STORE) ? rf_rdata2 : '0;
        taken_q <= (kind == WB_BRANCH) && (rf_rdata1 <= rf_rdata2);
      end
    end
  end

  always_comb begin
    state_next       = state;
    instr_ready      = 1'b0;
    rf_raddr1        = '0;
    rf_raddr2        = '0;
    alu_sel          = 5'b0;
    alu_i1           = '0;
    alu_i2           = '0;
    wb.wb_valid      = 1'b0;
    wb.wb_kind       = 2'b00;
    wb.wb_addr       = '0;
    wb.wb_data       = '0;
    wb.wb_store_data = '0;
    wb.branch_taken  = 1'b0;

    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = DECODE;
      end
      DECODE: begin
        rf_raddr1  = REG_AW'(instr_q[25:21]);
        rf_raddr2  = REG_AW'(instr_q[20:16]);
        state_next = EXEC;
      end
      EXEC: begin
        alu_sel = sel;
        alu_i1  = (i1_sel == I1_RS) ? rf_rdata1 : '0;
        case (i2_sel)
          I2_RT:   alu_i2 = rf_rdata2;
          I2_RS:   alu_i2 = rf_rdata1;
          I2_ZEXT: alu_i2 = {{(DATA_W-16){1'b0}}, instr_q[15:0]};
          I2_SEXT: alu_i2 = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
          default: alu_i2 = '0;
        endcase
        // Writes to r0 and unknown ops retire here without a writeback.
        if (!is_legal || (reg_write && dest == 5'd0)) state_next = IDLE;
        else                                          state_next = WB;
      end
      WB: begin
        wb.wb_valid      = 1'b1;
        wb.wb_kind       = kind_q;
        wb.wb_addr       = addr_q;
        wb.wb_data       = data_q;
        wb.wb_store_data = store_q;
        wb.branch_taken  = taken_q;
        if (wb.wb_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  assign illegal = (state == EXEC) && !is_legal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural regfile, a behavioural
// ALU and a scoreboard of expected writebacks built from instruction semantics.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [4:0]  alu_sel;
  logic [31:0] alu_i1, alu_i2, alu_o;
  logic        illegal;

  logic [31:0] regs [32];
  int total = 0;
  int bad   = 0;

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic        has_wb;
    logic        legal;
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] store;
    logic        taken;
    logic [4:0]  sel;
    logic [31:0] i1;
    logic [31:0] i2;
  } expT;

  expT sb[$];

  alu_issue_ctrl_if wbi ();

  alu_issue_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .alu_sel     (alu_sel),
    .alu_i1      (alu_i1),
    .alu_i2      (alu_i2),
    .alu_o       (alu_o),
    .wb          (wbi),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file
  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
  end

  // External ALU; bleu's O is defined here as I1-I2 (only branch_taken matters)
  always_comb begin
    logic [5:0] amt;
    amt = {3'b0, alu_i1[2:0]};
    case (alu_sel)
      5'b10000: alu_o = alu_i1 + alu_i2;
      5'b10011,
      5'b00111: alu_o = ~(alu_i1 | alu_i2);
      5'b00010: alu_o = ~alu_i2;
      5'b00000: alu_o = (alu_i2 << amt) | (alu_i2 >> (6'd32 - amt));
      5'b00001: alu_o = (alu_i2 >> amt) | (alu_i2 << (6'd32 - amt));
      5'b01000: alu_o = alu_i1 - alu_i2;
      default:  alu_o = 32'h0;
    endcase
  end

  function automatic logic [31:0] rType(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic expT model(input logic [31:0] ins);
    expT e;
    logic [5:0]  op, fn;
    logic [31:0] a, b, zx, sx;
    logic [63:0] dbl;
    logic        regWrite;
    e        = '0;
    regWrite = 1'b0;
    op  = ins[31:26];
    fn  = ins[5:0];
    a   = regs[ins[25:21]];
    b   = regs[ins[20:16]];
    zx  = {16'h0, ins[15:0]};
    sx  = {{16{ins[15]}}, ins[15:0]};
    e.legal = 1'b1;
    if (op == 6'h00 && fn == 6'h20) begin
      e.sel = 5'b10000; e.i1 = a; e.i2 = b; e.data = a + b; e.addr = ins[15:11]; regWrite = 1'b1;
    end else if (op == 6'h00 && fn == 6'h27) begin
      e.sel = 5'b10011; e.i1 = a; e.i2 = b; e.data = ~(a | b); e.addr = ins[15:11]; regWrite = 1'b1;
    end else if (op == 6'h00 && fn == 6'h28) begin
      e.sel = 5'b00010; e.i1 = 32'h0; e.i2 = a; e.data = ~a; e.addr = ins[15:11]; regWrite = 1'b1;
    end else if (op == 6'h00 && fn == 6'h04) begin
      dbl = {b, b} << a[2:0];
      e.sel = 5'b00000; e.i1 = a; e.i2 = b; e.data = dbl[63:32]; e.addr = ins[15:11]; regWrite = 1'b1;
    end else if (op == 6'h00 && fn == 6'h06) begin
      dbl = {b, b} >> a[2:0];
      e.sel = 5'b00001; e.i1 = a; e.i2 = b; e.data = dbl[31:0]; e.addr = ins[15:11]; regWrite = 1'b1;
    end else if (op == 6'h0E) begin
      e.sel = 5'b00111; e.i1 = a; e.i2 = zx; e.data = ~(a | zx); e.addr = ins[20:16]; regWrite = 1'b1;
    end else if (op == 6'h23) begin
      e.sel = 5'b10000; e.i1 = a; e.i2 = sx; e.data = a + sx; e.kind = 2'b01;
      e.addr = ins[20:16]; e.has_wb = 1'b1;
    end else if (op == 6'h2B) begin
      e.sel = 5'b10000; e.i1 = a; e.i2 = sx; e.data = a + sx; e.kind = 2'b10;
      e.store = b; e.has_wb = 1'b1;
    end else if (op == 6'h07) begin
      e.sel = 5'b01000; e.i1 = a; e.i2 = b; e.data = a - b; e.kind = 2'b11;
      e.taken = (a <= b); e.has_wb = 1'b1;
    end else begin
      e.legal = 1'b0;
    end
    if (regWrite) e.has_wb = (e.addr != 5'd0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers ins for one cycle from IDLE; returns at the DECODE-phase negedge
  task automatic applyStimulus(input logic [31:0] ins, input string tag);
    expT e;
    e = model(ins);
    @(negedge clk);
    checkOutput({tag, ".ready_idle"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr       = ins;
    if (e.has_wb) sb.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput({tag, ".ready_busy"}, instr_ready, 0);
    checkOutput({tag, ".raddr1"}, rf_raddr1, ins[25:21]);
    checkOutput({tag, ".raddr2"}, rf_raddr2, ins[20:16]);
  endtask

  // Expects to be called at a WB-phase negedge with wb_ready already high
  task automatic checkWb(input string tag);
    expT e;
    checkOutput({tag, ".wb_valid"}, wbi.wb_valid, 1);
    checkOutput({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({tag, ".kind"},  wbi.wb_kind,       e.kind);
      checkOutput({tag, ".addr"},  wbi.wb_addr,       e.addr);
      checkOutput({tag, ".data"},  wbi.wb_data,       e.data);
      checkOutput({tag, ".store"}, wbi.wb_store_data, e.store);
      checkOutput({tag, ".taken"}, wbi.branch_taken,  e.taken);
    end
    @(negedge clk);
    checkOutput({tag, ".wb_done"}, wbi.wb_valid, 0);
    checkOutput({tag, ".ready_back"}, instr_ready, 1);
  endtask

  task automatic runInstr(input logic [31:0] ins, input string tag);
    expT e;
    e = model(ins);
    applyStimulus(ins, tag);
    @(negedge clk);
    checkOutput({tag, ".sel"}, alu_sel, e.sel);
    checkOutput({tag, ".i1"}, alu_i1, e.i1);
    checkOutput({tag, ".i2"}, alu_i2, e.i2);
    checkOutput({tag, ".illegal"}, illegal, TRAP_EN && !e.legal);
    checkOutput({tag, ".wb_early"}, wbi.wb_valid, 0);
    @(negedge clk);
    checkOutput({tag, ".illegal_off"}, illegal, 0);
    if (e.has_wb) begin
      checkWb(tag);
    end else begin
      checkOutput({tag, ".no_wb"}, wbi.wb_valid, 0);
      checkOutput({tag, ".ready_back"}, instr_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1]  = 32'hFFFF_FFFF;  regs[2]  = 32'h2;
    regs[4]  = 32'h0000_000F;  regs[7]  = 32'h3;
    regs[8]  = 32'h1;          regs[9]  = 32'h1000;
    regs[10] = 32'hAB;         regs[11] = 32'h5;
    regs[12] = 32'h5;          regs[13] = 32'h6;
    regs[14] = 32'hFFFF_FFFF;  regs[15] = 32'hF9;
    regs[16] = 32'h1234_5678;

    reset_n      = 1'b0;
    instr_valid  = 1'b0;
    instr        = 32'h0;
    wbi.wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst.ready",    instr_ready,  1);
    checkOutput("rst.wb_valid", wbi.wb_valid, 0);
    checkOutput("rst.wb_data",  wbi.wb_data,  0);
    checkOutput("rst.sel",      alu_sel,      0);
    checkOutput("rst.i1",       alu_i1,       0);
    checkOutput("rst.raddr1",   rf_raddr1,    0);
    checkOutput("rst.illegal",  illegal,      0);
    reset_n = 1'b1;

    runInstr(rType(6'h20, 5'd1, 5'd2, 5'd3), "add");
    runInstr(iType(6'h0E, 5'd4, 5'd5, 16'h00F0), "nori");
    runInstr(rType(6'h06, 5'd7, 5'd8, 5'd6), "rorv3");
    runInstr(rType(6'h06, 5'd15, 5'd8, 5'd6), "rorv_f9");
    runInstr(rType(6'h04, 5'd7, 5'd16, 5'd17), "rolv");
    runInstr(rType(6'h27, 5'd16, 5'd10, 5'd18), "nor");
    runInstr(rType(6'h28, 5'd16, 5'd0, 5'd19), "not");
    runInstr(iType(6'h23, 5'd9, 5'd0, 16'h8000), "lw_r0");
    runInstr(iType(6'h2B, 5'd9, 5'd10, 16'hFFFC), "sw");
    runInstr(iType(6'h07, 5'd11, 5'd12, 16'h0), "bleu_eq");
    runInstr(iType(6'h07, 5'd13, 5'd12, 16'h0), "bleu_gt");
    runInstr(iType(6'h07, 5'd14, 5'd2, 16'h0), "bleu_uns");
    runInstr(rType(6'h20, 5'd1, 5'd2, 5'd0), "add_r0");
    runInstr(32'hFC00_0000, "op3f");
    runInstr(rType(6'h3F, 5'd1, 5'd2, 5'd3), "badfn");

    // Backpressure: result must hold while a second instruction is refused
    wbi.wb_ready = 1'b0;
    applyStimulus(rType(6'h20, 5'd16, 5'd10, 5'd20), "stall");
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = rType(6'h27, 5'd1, 5'd2, 5'd21);
      checkOutput("stall.wb_valid", wbi.wb_valid, 1);
      checkOutput("stall.data", wbi.wb_data, sb[0].data);
      checkOutput("stall.addr", wbi.wb_addr, sb[0].addr);
      checkOutput("stall.ready", instr_ready, 0);
    end
    instr_valid  = 1'b0;
    wbi.wb_ready = 1'b1;
    checkWb("stall");

    // Reset in EXEC discards the instruction
    applyStimulus(rType(6'h20, 5'd1, 5'd2, 5'd3), "rst_exec");
    sb.delete();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_exec.wb_valid", wbi.wb_valid, 0);
    checkOutput("rst_exec.ready", instr_ready, 1);
    checkOutput("rst_exec.sel", alu_sel, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_exec.still_idle", wbi.wb_valid, 0);

    runInstr(rType(6'h20, 5'd1, 5'd2, 5'd3), "add_after_rst");
    checkOutput("sb.drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
